pix_source_sequencer: RTL

Front-end sequencer for the octave/DoG pipeline. Selects the pixel source (live camera stream or SPI-injected frames from the host), packs SPI bytes into pixel pairs, generates the single pixel-enable and frame-reset strobes the octave modules consume, and tracks pixel coordinates. Source switches are applied only on frame boundaries, so the downstream line buffers never see a frame made of mixed sources.

---
 rtl/pix_source_sequencer_if.sv | 35 +++
 rtl/pix_source_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pix_source_sequencer_if.sv
// Pixel-source bundle: camera and SPI inputs toward the sequencer, octave-facing
// pixel strobes and coordinates back out.
interface pix_source_sequencer_if;
    logic        mode_req;
    logic        cam_dv;
    logic        cam_rst;
    logic [15:0] cam_pix1;
    logic [15:0] cam_pix2;
    logic [7:0]  spi_byte;
    logic        spi_byte_vld;
    logic        spi_frame_rst;
    logic        pix_en;
    logic        pix_rst;
    logic [15:0] pix1;
    logic [15:0] pix2;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_done;
    logic        mode_act;
    logic        err_partial;

    modport slave (
        input  mode_req, cam_dv, cam_rst, cam_pix1, cam_pix2,
               spi_byte, spi_byte_vld, spi_frame_rst,
        output pix_en, pix_rst, pix1, pix2, pix_x, pix_y,
               frame_done, mode_act, err_partial
    );

    modport master (
        output mode_req, cam_dv, cam_rst, cam_pix1, cam_pix2,
               spi_byte, spi_byte_vld, spi_frame_rst,
        input  pix_en, pix_rst, pix1, pix2, pix_x, pix_y,
               frame_done, mode_act, err_partial
    );
endinterface

// File: rtl/pix_source_sequencer.sv
// Selects camera or SPI pixel source, packs SPI bytes into RGB565 pairs and
// emits pixel/frame strobes with coordinates; source changes only at frame boundaries.
module pix_source_sequencer #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480
) (
    input logic                   clk,
    input logic                   rst,
    pix_source_sequencer_if.slave bus
);

    typedef enum logic [1:0] {S_CAM, S_SPI, S_SWITCH} state_t;

    state_t      state;
    logic        mode_act_p1;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [2:0]  byte_cnt;
    logic [7:0]  byte_buf [0:4];

    logic        pix_en_p1;
    logic        pix_rst_p1;
    logic        frame_done_p1;
    logic        err_partial_p1;
    logic [15:0] pix1_p1;
    logic [15:0] pix2_p1;
    logic [10:0] pix_x_p1;
    logic [10:0] pix_y_p1;

    logic        pending;
    logic        boundary;
    logic        last_x;
    logic        last_pix;
    logic [10:0] x_nxt;
    logic [10:0] y_nxt;

    function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    always_comb begin
        pending  = (bus.mode_req != mode_act_p1);
        boundary = (x_cnt == 11'd0) && (y_cnt == 11'd0) && (byte_cnt == 3'd0);
        last_x   = (x_cnt == 11'(FRAME_W - 1));
        last_pix = last_x && (y_cnt == 11'(FRAME_H - 1));
        x_nxt    = last_x ? 11'd0 : x_cnt + 11'd1;
        y_nxt    = y_cnt;
        if (last_x) y_nxt = last_pix ? 11'd0 : y_cnt + 11'd1;
    end

    // Stage p1: registered strobes, pixels and coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_CAM;
            mode_act_p1    <= 1'b0;
            x_cnt          <= '0;
            y_cnt          <= '0;
            byte_cnt       <= '0;
            pix_en_p1      <= 1'b0;
            pix_rst_p1     <= 1'b0;
            frame_done_p1  <= 1'b0;
            err_partial_p1 <= 1'b0;
            pix1_p1        <= '0;
            pix2_p1        <= '0;
            pix_x_p1       <= '0;
            pix_y_p1       <= '0;
        end else begin
            pix_en_p1      <= 1'b0;
            pix_rst_p1     <= 1'b0;
            frame_done_p1  <= 1'b0;
            err_partial_p1 <= 1'b0;
            case (state)
                S_CAM: begin
                    byte_cnt <= '0;
                    if (pending && (bus.cam_rst || boundary)) begin
                        state      <= S_SWITCH;
                        pix_rst_p1 <= 1'b1;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                    end else if (bus.cam_rst) begin
                        pix_rst_p1 <= 1'b1;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                    end else if (bus.cam_dv) begin
                        pix_en_p1     <= 1'b1;
                        pix1_p1       <= bus.cam_pix1;
                        pix2_p1       <= bus.cam_pix2;
                        pix_x_p1      <= x_cnt;
                        pix_y_p1      <= y_cnt;
                        frame_done_p1 <= last_pix;
                        x_cnt         <= x_nxt;
                        y_cnt         <= y_nxt;
                    end
                end
                S_SPI: begin
                    // A host frame reset always wins over a coincident byte strobe
                    if (bus.spi_frame_rst || (pending && boundary)) begin
                        if (pending) state <= S_SWITCH;
                        pix_rst_p1     <= 1'b1;
                        err_partial_p1 <= bus.spi_frame_rst && (byte_cnt != 3'd0);
                        x_cnt          <= '0;
                        y_cnt          <= '0;
                        byte_cnt       <= '0;
                    end else if (bus.spi_byte_vld) begin
                        if (byte_cnt == 3'd5) begin
                            pix_en_p1     <= 1'b1;
                            pix1_p1       <= pack565(byte_buf[0], byte_buf[1], byte_buf[2]);
                            pix2_p1       <= pack565(byte_buf[3], byte_buf[4], bus.spi_byte);
                            pix_x_p1      <= x_cnt;
                            pix_y_p1      <= y_cnt;
                            frame_done_p1 <= last_pix;
                            x_cnt         <= x_nxt;
                            y_cnt         <= y_nxt;
                            byte_cnt      <= '0;
                        end else begin
                            byte_buf[byte_cnt] <= bus.spi_byte;
                            byte_cnt           <= byte_cnt + 3'd1;
                        end
                    end
                end
                S_SWITCH: begin
                    state       <= bus.mode_req ? S_SPI : S_CAM;
                    mode_act_p1 <= bus.mode_req;
                    x_cnt       <= '0;
                    y_cnt       <= '0;
                    byte_cnt    <= '0;
                end
                default: state <= S_CAM;
            endcase
        end
    end

    assign bus.pix_en      = pix_en_p1;
    assign bus.pix_rst     = pix_rst_p1;
    assign bus.frame_done  = frame_done_p1;
    assign bus.err_partial = err_partial_p1;
    assign bus.pix1        = pix1_p1;
    assign bus.pix2        = pix2_p1;
    assign bus.pix_x       = pix_x_p1;
    assign bus.pix_y       = pix_y_p1;
    assign bus.mode_act    = mode_act_p1;

endmodule
